// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM encoding,
// timeout counter width and request legality helpers.
// Optional build macro: LSU_MISALIGN_CHECK_EN (used by load_store_unit).
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int CNT_W = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    // 011/110/111 never exist; unsigned variants only make sense for loads.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        logic bad;
        bad = 1'b0;
        case (f3)
            F3_B, F3_H, F3_W: bad = 1'b0;
            F3_BU, F3_HU:     bad = we;
            default:          bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes are always aligned.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic mis;
        mis = 1'b0;
        case (f3[1:0])
            2'b01:   mis = lo[0];
            2'b10:   mis = (lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane extraction plus sign/zero
// extension for loads. Purely combinational.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] byte_sh;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Halfword lane comes from addr[1] only, so a misaligned halfword
    // (when not trapped) silently uses the aligned lane; words use all lanes.
    always_comb begin
        be_o    = 4'b0000;
        wdata_o = 32'h0;
        case (funct3_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
            end
        endcase
    end

    // Select the addressed byte/halfword of the read word and extend it.
    always_comb begin
        byte_sh = rdata_i >> {addr_lo_i, 3'b000};
        ld_byte = byte_sh[7:0];
        ld_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        rdata_o = 32'h0;
        case (funct3_i)
            F3_B:    rdata_o = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   rdata_o = {24'h0, ld_byte};
            F3_H:    rdata_o = {{16{ld_half[15]}}, ld_half};
            F3_HU:   rdata_o = {16'h0, ld_half};
            F3_W:    rdata_o = rdata_i;
            default: rdata_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: one transaction at a time on a
// req/gnt/rvalid bus, with a cycle-bounded wait and one response per request.
// Optional build macro: LSU_MISALIGN_CHECK_EN (misaligned H/W accesses
// answered with rsp_err and no bus access).
//
// Handshakes: a core request is taken on a clk edge where req_valid and
// req_ready are both high; mem_req is held until the edge where mem_gnt is
// high; mem_rvalid only counts in WAIT; rsp_valid is a single-cycle pulse.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [CNT_W:0] TO_LIM = (CNT_W+1)'(TIMEOUT_CYC);

    lsu_state_e      state_q, state_d;
    logic            we_q, we_d;
    logic [2:0]      f3_q, f3_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [CNT_W:0]  cnt_inc;
    logic [CNT_W-1:0] cnt_sat;
    logic            timeout_hit;
    logic            req_bad;
    logic [3:0]      al_be;
    logic [31:0]     al_wdata;
    logic [31:0]     al_rdata;

    lsu_align u_align (
        .funct3_i  (f3_q),
        .addr_lo_i (addr_q[1:0]),
        .wdata_i   (wdata_q),
        .rdata_i   (mem_rdata),
        .be_o      (al_be),
        .wdata_o   (al_wdata),
        .rdata_o   (al_rdata)
    );

    // Request classification done on the live request so errors skip the bus.
    always_comb begin
`ifdef LSU_MISALIGN_CHECK_EN
        req_bad = f3_illegal(req_we, req_funct3) | f3_misaligned(req_funct3, req_addr[1:0]);
`else
        req_bad = f3_illegal(req_we, req_funct3);
`endif
    end

    // Cycle count including the current one; saturates so it can never wrap.
    always_comb begin
        cnt_inc     = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
        cnt_sat     = cnt_inc[CNT_W] ? cnt_q : cnt_inc[CNT_W-1:0];
        timeout_hit = (cnt_inc >= TO_LIM);
    end

    // Next-state and datapath updates; bus events take priority over timeout.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = 32'h0;
                    cnt_d   = '0;
                    err_d   = req_bad;
                    state_d = req_bad ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                cnt_d = cnt_sat;
                if (mem_gnt) begin
                    state_d = we_q ? RESP : WAIT;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            WAIT: begin
                cnt_d = cnt_sat;
                if (mem_rvalid) begin
                    rdata_d = al_rdata;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and transaction registers; reset abandons any transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decoded from registered state; bus fields are zero off-bus.
    always_comb begin
        req_ready = (state_q == IDLE);
        mem_req   = (state_q == ISSUE);
        rsp_valid = (state_q == RESP);
        rsp_err   = rsp_valid & err_q;
        rsp_rdata = rsp_valid ? rdata_q : 32'h0;
        mem_we    = mem_req & we_q;
        mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'h0;
        mem_be    = mem_req ? al_be : 4'b0000;
        mem_wdata = (mem_req & we_q) ? al_wdata : 32'h0;
    end

endmodule
